// File: rtl/modport_fifo_pkg.sv
// modport_fifo_pkg: shared defaults and address-width helper for the FIFO and its storage
package modport_fifo_pkg;

    localparam int DEF_FIFO_WIDTH = 32;
    localparam int DEF_FIFO_DEPTH = 32;

    function automatic int addr_width(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// fifo_mem: FIFO_DEPTH x FIFO_WIDTH register array with a synchronous write port and a registered read port
//   clk, rstN          clock and synchronous active-high reset (clears only the read register)
//   i_we/i_waddr/i_wdata  write port
//   i_re/i_raddr       read port; o_rdata updates one edge after i_re and holds otherwise
module fifo_mem
    import modport_fifo_pkg::*;
#(
    parameter int FIFO_WIDTH = DEF_FIFO_WIDTH,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int AW = addr_width(FIFO_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rstN,
    input  logic                  i_we,
    input  logic [AW-1:0]         i_waddr,
    input  logic [FIFO_WIDTH-1:0] i_wdata,
    input  logic                  i_re,
    input  logic [AW-1:0]         i_raddr,
    output logic [FIFO_WIDTH-1:0] o_rdata
);

    logic [FIFO_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [FIFO_WIDTH-1:0] r_rdata;

    // Storage is deliberately left uninitialised on reset.
    always_ff @(posedge clk) begin
        if (i_we)
            r_mem[i_waddr] <= i_wdata;
    end

    // A same-address read and write returns the old word, which is what a full FIFO doing read+write needs.
    always_ff @(posedge clk) begin
        if (rstN)
            r_rdata <= '0;
        else if (i_re)
            r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/modport_fifo.sv
// modport_fifo: single-clock FIFO with registered read data and full/empty flags
//   clk, rstN            clock and synchronous active-high reset
//   wr_en, data_in       producer side write request and data
//   rd_en, data_out      consumer side read request and registered read data
//   empty, full          status flags derived from the current occupancy
module modport_fifo
    import modport_fifo_pkg::*;
#(
    parameter int FIFO_WIDTH = DEF_FIFO_WIDTH,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                  clk,
    input  logic                  rstN,
    input  logic                  wr_en,
    input  logic [FIFO_WIDTH-1:0] data_in,
    input  logic                  rd_en,
    output logic                  empty,
    output logic                  full,
    output logic [FIFO_WIDTH-1:0] data_out
);

    localparam int AW = addr_width(FIFO_DEPTH);
    localparam logic [AW:0] L_FULL = (AW+1)'(FIFO_DEPTH);

    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_rd_acc;
    logic          w_wr_acc;

    assign empty    = (r_count == '0);
    assign full     = (r_count == L_FULL);
    assign w_rd_acc = rd_en & ~empty;
    // A full FIFO still accepts a write when a read frees a slot in the same cycle.
    assign w_wr_acc = wr_en & (~full | w_rd_acc);

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk) begin
        if (rstN) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_acc)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd_acc)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + (AW+1)'(w_wr_acc) - (AW+1)'(w_rd_acc);
        end
    end

    fifo_mem #(
        .FIFO_WIDTH(FIFO_WIDTH),
        .FIFO_DEPTH(FIFO_DEPTH),
        .AW        (AW)
    ) u_mem (
        .clk    (clk),
        .rstN   (rstN),
        .i_we   (w_wr_acc),
        .i_waddr(r_wr_ptr),
        .i_wdata(data_in),
        .i_re   (w_rd_acc),
        .i_raddr(r_rd_ptr),
        .o_rdata(data_out)
    );

endmodule

// File: tb/tb_modport_fifo.sv
// tb_modport_fifo: directed self-checking bench for modport_fifo
module tb_modport_fifo;

    logic        clk = 1'b0;
    logic        rstN = 1'b1;
    logic        wr_en = 1'b0;
    logic [31:0] data_in = '0;
    logic        rd_en = 1'b0;
    logic        empty;
    logic        full;
    logic [31:0] data_out;
    int          n_checks = 0;
    int          n_fail = 0;

    modport_fifo dut (
        .clk     (clk),
        .rstN    (rstN),
        .wr_en   (wr_en),
        .data_in (data_in),
        .rd_en   (rd_en),
        .empty   (empty),
        .full    (full),
        .data_out(data_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input logic w, input logic [31:0] d, input logic r);
        wr_en   = w;
        data_in = d;
        rd_en   = r;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    initial begin
        // reset held two cycles while both requests are active
        rstN = 1'b1;
        step(1'b1, 32'h55, 1'b1);
        step(1'b1, 32'h56, 1'b1);
        check("rst_empty", {31'b0, empty}, 32'd1);
        check("rst_full", {31'b0, full}, 32'd0);
        check("rst_dout", data_out, 32'd0);
        rstN = 1'b0;
        step(1'b0, 32'h0, 1'b0);
        check("rst_noentries", {31'b0, empty}, 32'd1);
        // fill
        for (int i = 0; i < 32; i++) begin
            step(1'b1, 32'(i), 1'b0);
            if (i == 30) check("fill31_notfull", {31'b0, full}, 32'd0);
        end
        check("fill_full", {31'b0, full}, 32'd1);
        check("fill_notempty", {31'b0, empty}, 32'd0);
        // overflow write is dropped
        step(1'b1, 32'hDEAD, 1'b0);
        check("ovf_full", {31'b0, full}, 32'd1);
        // drain in order
        for (int i = 0; i < 32; i++) begin
            step(1'b0, 32'h0, 1'b1);
            check($sformatf("drain%0d", i), data_out, 32'(i));
        end
        check("drain_empty", {31'b0, empty}, 32'd1);
        // underflow
        step(1'b0, 32'h0, 1'b1);
        check("udf_dout", data_out, 32'h1F);
        check("udf_empty", {31'b0, empty}, 32'd1);
        // write+read on empty: write lands, no fall-through
        step(1'b1, 32'h77, 1'b1);
        check("nofall_dout", data_out, 32'h1F);
        check("nofall_notempty", {31'b0, empty}, 32'd0);
        step(1'b0, 32'h0, 1'b1);
        check("nofall_read", data_out, 32'h77);
        check("nofall_empty", {31'b0, empty}, 32'd1);
        // simultaneous at count=5
        for (int i = 0; i < 5; i++) step(1'b1, 32'h100 + 32'(i), 1'b0);
        step(1'b1, 32'h105, 1'b1);
        check("rw5_dout", data_out, 32'h100);
        for (int i = 1; i <= 5; i++) begin
            step(1'b0, 32'h0, 1'b1);
            check($sformatf("rw5_drain%0d", i), data_out, 32'h100 + 32'(i));
        end
        check("rw5_empty", {31'b0, empty}, 32'd1);
        // simultaneous at full
        for (int i = 0; i < 32; i++) step(1'b1, 32'h200 + 32'(i), 1'b0);
        step(1'b1, 32'hAAAA, 1'b1);
        check("rwfull_dout", data_out, 32'h200);
        check("rwfull_full", {31'b0, full}, 32'd1);
        for (int i = 1; i < 32; i++) begin
            step(1'b0, 32'h0, 1'b1);
            check($sformatf("rwfull_drain%0d", i), data_out, 32'h200 + 32'(i));
        end
        step(1'b0, 32'h0, 1'b1);
        check("rwfull_last", data_out, 32'hAAAA);
        check("rwfull_empty", {31'b0, empty}, 32'd1);
        // wrap-around: pointers start at 8 here, so 60 words cross 31->0
        for (int k = 0; k < 3; k++) begin
            for (int j = 0; j < 20; j++) step(1'b1, 32'h300 + 32'(k * 20 + j), 1'b0);
            for (int j = 0; j < 20; j++) begin
                step(1'b0, 32'h0, 1'b1);
                check($sformatf("wrap%0d_%0d", k, j), data_out, 32'h300 + 32'(k * 20 + j));
            end
        end
        check("wrap_empty", {31'b0, empty}, 32'd1);
        // reset mid-operation at count=10
        for (int i = 0; i < 10; i++) step(1'b1, 32'h400 + 32'(i), 1'b0);
        rstN = 1'b1;
        step(1'b0, 32'h0, 1'b0);
        rstN = 1'b0;
        check("midrst_empty", {31'b0, empty}, 32'd1);
        check("midrst_full", {31'b0, full}, 32'd0);
        check("midrst_dout", data_out, 32'd0);
        step(1'b1, 32'hBEEF, 1'b0);
        step(1'b0, 32'h0, 1'b1);
        check("midrst_new", data_out, 32'hBEEF);
        check("midrst_final_empty", {31'b0, empty}, 32'd1);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
